// File: rtl/gcd_controller.sv
// gcd_controller
// Control FSM for the subtract-and-compare GCD datapath. It accepts an
// operand pair through a start/ready handshake and drives the datapath mux
// selects and register loads. The comparator flags steer each iteration.
// output_en is raised when the operands compare equal. A one-cycle done or
// err pulse reports the outcome.
//
// Parameters
//   WIDTH     operand width, must match the datapath
//   MAX_ITER  subtraction cycles allowed before the operation aborts
//   CNT_W     iteration counter width, must be able to hold MAX_ITER
//
// Ports
//   clk                 rising-edge clock
//   rst                 synchronous active-low reset, shared with the datapath
//   start               request, sampled only while in_ready=1
//   data_in1/data_in2   operands, inspected here for zero only
//   a_gt_b/a_eq_b/a_lt_b comparator flags from the datapath
//   a_sel/b_sel         1 = load the operand bus, 0 = load the difference
//   a_ld/b_ld           A / B register load enables
//   output_en           result register load enable
//   in_ready            high only in IDLE
//   busy                high in RUN
//   done/err            one-cycle completion / error pulses
//   iter_cnt            subtractions in the current or last operation
module gcd_controller #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_ITER = 255,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in1,
  input  logic [WIDTH-1:0] data_in2,
  input  logic             a_gt_b,
  input  logic             a_eq_b,
  input  logic             a_lt_b,
  output logic             a_sel,
  output logic             b_sel,
  output logic             a_ld,
  output logic             b_ld,
  output logic             output_en,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] iter_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] ITER_LIMIT = CNT_W'(MAX_ITER);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             operands_ok;

  assign operands_ok = (data_in1 != '0) && (data_in2 != '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      iter_cnt <= '0;
    end else begin
      state    <= state_nxt;
      iter_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = iter_cnt;
    a_sel     = 1'b0;
    b_sel     = 1'b0;
    a_ld      = 1'b0;
    b_ld      = 1'b0;
    output_en = 1'b0;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;

    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (start) begin
          if (operands_ok) begin
            a_sel     = 1'b1;
            b_sel     = 1'b1;
            a_ld      = 1'b1;
            b_ld      = 1'b1;
            cnt_nxt   = '0;
            state_nxt = RUN;
          end else begin
            // Zero operand: nothing is loaded and iter_cnt keeps its value.
            state_nxt = ERR;
          end
        end
      end

      RUN: begin
        busy = 1'b1;
        // Equality wins over the limit check: a pair that converges on the
        // last permitted subtraction still completes normally.
        if (a_eq_b) begin
          output_en = 1'b1;
          state_nxt = DONE;
        end else if (iter_cnt == ITER_LIMIT) begin
          state_nxt = ERR;
        end else if (a_gt_b) begin
          a_ld    = 1'b1;
          cnt_nxt = iter_cnt + CNT_W'(1);
        end else if (a_lt_b) begin
          b_ld    = 1'b1;
          cnt_nxt = iter_cnt + CNT_W'(1);
        end
      end

      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end

      ERR: begin
        err       = 1'b1;
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_gcd_controller.sv
// Testbench for gcd_controller. Two instances share the stimulus: one with
// the default iteration limit and one with a small limit so that the
// overflow abort is reachable. Each instance drives its own behavioural
// datapath. Expected responses are queued at issue time and matched by an
// independent monitor whenever done or err pulses.
module tb_gcd_controller;

  localparam int NCH = 2;
  localparam int MAX_SMALL = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] d1, d2;

  logic [NCH-1:0] gt, eq, lt;
  logic [NCH-1:0] a_sel, b_sel, a_ld, b_ld, oen, in_ready, busy, done, err;
  logic [7:0]     ic0;
  logic [3:0]     ic1;

  logic [7:0] ra [NCH];
  logic [7:0] rb [NCH];
  logic [7:0] rout [NCH];

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    bit is_err;
    int res;
    int icnt;
    bit chk_cnt;
    int when;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   last_res [NCH];
  int   max_iter [NCH];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gcd_controller #(.WIDTH(8), .MAX_ITER(255), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .start(start), .data_in1(d1), .data_in2(d2),
    .a_gt_b(gt[0]), .a_eq_b(eq[0]), .a_lt_b(lt[0]),
    .a_sel(a_sel[0]), .b_sel(b_sel[0]), .a_ld(a_ld[0]), .b_ld(b_ld[0]),
    .output_en(oen[0]), .in_ready(in_ready[0]), .busy(busy[0]),
    .done(done[0]), .err(err[0]), .iter_cnt(ic0)
  );

  gcd_controller #(.WIDTH(8), .MAX_ITER(MAX_SMALL), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .start(start), .data_in1(d1), .data_in2(d2),
    .a_gt_b(gt[1]), .a_eq_b(eq[1]), .a_lt_b(lt[1]),
    .a_sel(a_sel[1]), .b_sel(b_sel[1]), .a_ld(a_ld[1]), .b_ld(b_ld[1]),
    .output_en(oen[1]), .in_ready(in_ready[1]), .busy(busy[1]),
    .done(done[1]), .err(err[1]), .iter_cnt(ic1)
  );

  // Behavioural datapath per instance.
  always_comb begin
    gt = '0;
    eq = '0;
    lt = '0;
    for (int i = 0; i < NCH; i++) begin
      gt[i] = ra[i] > rb[i];
      eq[i] = ra[i] == rb[i];
      lt[i] = ra[i] < rb[i];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (!rst) begin
        ra[i]   <= '0;
        rb[i]   <= '0;
        rout[i] <= '0;
      end else begin
        if (a_ld[i]) ra[i] <= a_sel[i] ? d1 : ra[i] - rb[i];
        if (b_ld[i]) rb[i] <= b_sel[i] ? d2 : rb[i] - ra[i];
        if (oen[i])  rout[i] <= ra[i];
      end
    end
  end

  // Euclid by division: each quotient q is q subtractions, except the
  // final step, which stops one short because equality ends the loop.
  function automatic void ref_gcd(input int a, input int b, output int g, output int k);
    int x, y, t;
    x = a;
    y = b;
    k = 0;
    while (y != 0) begin
      k += x / y;
      t = x % y;
      x = y;
      y = t;
    end
    g = x;
    k = k - 1;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic check_resp(input int ch, input bit dn, input bit er, input int ov, input int ic);
    exp_t e;
    int   qs;
    n_chk++;
    qs = (ch == 0) ? q0.size() : q1.size();
    if (qs == 0) begin
      n_fail++;
      $display("FAIL spurious_resp ch%0d: got done=%0b err=%0b at cyc %0d, want no response", ch, dn, er, cyc);
      return;
    end
    e = (ch == 0) ? q0.pop_front() : q1.pop_front();
    if (dn != !e.is_err || er != e.is_err || ov != e.res || cyc != e.when ||
        (e.chk_cnt && ic != e.icnt)) begin
      n_fail++;
      $display("FAIL resp ch%0d: got done=%0b err=%0b out=%0d iter=%0d cyc=%0d, want done=%0b err=%0b out=%0d iter=%0d cyc=%0d",
               ch, dn, er, ov, ic, cyc, !e.is_err, e.is_err, e.res, e.icnt, e.when);
    end
  endtask

  // Monitor: matches responses and checks per-cycle invariants.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      for (int i = 0; i < NCH; i++) begin
        if (done[i] || err[i])
          check_resp(i, done[i], err[i], int'(rout[i]), (i == 0) ? int'(ic0) : int'(ic1));
        n_chk++;
        if ((a_ld[i] && b_ld[i] && busy[i]) || (oen[i] && !busy[i]) ||
            (in_ready[i] && busy[i]) || (done[i] && err[i])) begin
          n_fail++;
          $display("FAIL invariant ch%0d: got a_ld=%0b b_ld=%0b oen=%0b rdy=%0b busy=%0b done=%0b err=%0b, want exclusive",
                   i, a_ld[i], b_ld[i], oen[i], in_ready[i], busy[i], done[i], err[i]);
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (in_ready !== 2'b11 && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 2'b11) begin
      n_chk++;
      n_fail++;
      $display("FAIL idle_timeout: got in_ready=%b, want 11", in_ready);
    end
  endtask

  task automatic push_expect(input int x, input int y);
    int   g, k;
    exp_t e;
    if (x != 0 && y != 0) ref_gcd(x, y, g, k);
    else begin
      g = 0;
      k = 0;
    end
    for (int i = 0; i < NCH; i++) begin
      if (x == 0 || y == 0) begin
        e = '{is_err: 1'b1, res: last_res[i], icnt: 0, chk_cnt: 1'b0, when: cyc + 1};
      end else if (k > max_iter[i]) begin
        e = '{is_err: 1'b1, res: last_res[i], icnt: max_iter[i], chk_cnt: 1'b1, when: cyc + max_iter[i] + 2};
      end else begin
        e = '{is_err: 1'b0, res: g, icnt: k, chk_cnt: 1'b1, when: cyc + k + 2};
        last_res[i] = g;
      end
      if (i == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endtask

  task automatic run_op(input int x, input int y);
    @(negedge clk);
    wait_idle();
    push_expect(x, y);
    d1 = 8'(x);
    d2 = 8'(y);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    d1 = 8'($urandom);
    d2 = 8'($urandom);
  endtask

  initial begin
    int x, y;
    max_iter[0] = 255;
    max_iter[1] = MAX_SMALL;
    last_res[0] = 0;
    last_res[1] = 0;
    rst = 1'b0;
    start = 1'b0;
    d1 = '0;
    d2 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    chk("rst_in_ready", int'(in_ready), 3);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done_err", int'({done, err}), 0);
    chk("rst_loads", int'({a_sel, b_sel, a_ld, b_ld, oen}), 0);
    chk("rst_iter0", int'(ic0), 0);
    chk("rst_iter1", int'(ic1), 0);

    run_op(12, 8);
    run_op(255, 1);
    run_op(0, 9);
    run_op(9, 0);
    run_op(7, 7);
    run_op(7, 1);   // exactly the small limit: completes
    run_op(8, 1);   // one past the small limit: aborts

    // Reset during RUN, with start raised while busy.
    @(negedge clk);
    wait_idle();
    push_expect(200, 3);
    d1 = 8'd200;
    d2 = 8'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    d1 = 8'd5;
    d2 = 8'd5;
    repeat (2) @(negedge clk);
    chk("midrun_busy", int'(busy), 3);
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    q0.delete();
    q1.delete();
    last_res[0] = 0;
    last_res[1] = 0;
    chk("abort_in_ready", int'(in_ready), 3);
    chk("abort_iter0", int'(ic0), 0);
    chk("abort_done_err", int'({done, err}), 0);

    run_op(21, 14);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        x = int'($urandom_range(1, 15));
        y = int'($urandom_range(1, 15));
      end else begin
        x = int'($urandom_range(1, 255));
        y = int'($urandom_range(1, 255));
      end
      if ($urandom_range(0, 9) == 0) x = 0;
      if ($urandom_range(0, 9) == 0) y = 0;
      if ($urandom_range(0, 9) == 0) y = x;
      run_op(x, y);
    end

    @(negedge clk);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("pending_ch0", q0.size(), 0);
    chk("pending_ch1", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
